// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the runtime-programmable sequence detector.
// Used by seq_detect_param and seq_match_cmp.
package seq_detect_pkg;

    localparam int unsigned MASK_MAX_W = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Low-len ones mask, sized for the largest supported pattern.
    function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare of {history, newest bit} against the loaded pattern,
// considering only the low i_len bits.
module seq_match_cmp
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic [PAT_W-2:0] i_hist,
    input  logic             i_x,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_eq_c
);

    logic [MASK_MAX_W-1:0] w_mask;
    logic [MASK_MAX_W-1:0] w_data;
    logic [MASK_MAX_W-1:0] w_pat;

    assign w_mask = len_mask(32'(i_len));
    assign w_data = MASK_MAX_W'({i_hist, i_x});
    assign w_pat  = MASK_MAX_W'(i_pat);
    assign o_eq_c = (((w_data ^ w_pat) & w_mask) == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector (1..PAT_W bit patterns).
// Define SEQ_DETECT_CNT_EN to build the saturating hit counter; otherwise hit_cnt is 0.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             x,
    input  logic             x_vld,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    output logic             y,
    output logic             y_reg,
    output logic             armed,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [HIST_W-1:0]  r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_y_reg;

    logic w_accept;
    logic w_fill_ok;
    logic w_eq;
    logic w_match;
    logic w_len_legal;

    assign w_accept    = (r_state == ARMED) && x_vld && !pat_load;
    assign w_fill_ok   = (({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len});
    assign w_match     = w_accept && w_fill_ok && w_eq;
    assign w_len_legal = (pat_len != '0) && (32'(pat_len) <= PAT_W);

    seq_match_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .i_hist (r_hist),
        .i_x    (x),
        .i_pat  (r_pat),
        .i_len  (r_len),
        .o_eq_c (w_eq)
    );

    // FSM, pattern registers, history and fill.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_ovl   <= 1'b0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_y_reg <= 1'b0;
        end else begin
            r_y_reg <= w_match;
            if (pat_load) begin
                r_pat   <= pat;
                r_len   <= pat_len;
                r_ovl   <= overlap;
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= w_len_legal ? ARMED : IDLE;
            end else if (w_accept) begin
                // Non-overlapping: the completing bit must not seed the next match.
                if (w_match && !r_ovl) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= HIST_W'({r_hist, x});
                    if (r_fill != FILL_MAX) begin
                        r_fill <= r_fill + LEN_W'(1);
                    end
                end
            end
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (pat_load) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt = r_cnt;
`else
    assign hit_cnt = '0;
`endif

    assign y     = w_match;
    assign y_reg = r_y_reg;
    assign armed = (r_state == ARMED);

endmodule
